jtag_shift_engine: RTL and testbench

Synthesizable JTAG master for the jtag_vpi/jtag_dpi test environment. It takes packed shift commands of up to MAX_BITS bits and generates TCK from clk with a programmable divider. It drives TMS/TDI onto one of NUM_CHAINS independent TAP chains and returns captured TDO in a response beat. It generalises the single-chain, host-driven bit-banging of jtag_dpi to a parametrised, cycle-deterministic hardware engine.

---
 rtl/jtag_pkg.sv | 31 +++
 rtl/jtag_shift_engine_tck_gen.sv | 41 ++++
 rtl/jtag_shift_engine.sv | 146 ++++++++++++++
 tb/tb_jtag_shift_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types for the JTAG shift engine: FSM states, width helpers
// and a packed command bundle for fixed 64-bit command users.
package jtag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        RESP
    } state_t;

    function automatic int len_w(input int max_bits);
        return $clog2(max_bits + 1);
    endfunction

    function automatic int sel_w(input int num_chains);
        return (num_chains > 1) ? $clog2(num_chains) : 1;
    endfunction

    localparam int CMD_MAX_BITS = 64;
    localparam int CMD_LEN_W    = len_w(CMD_MAX_BITS);
    localparam int CMD_SEL_W    = 1;

    typedef struct packed {
        logic [CMD_LEN_W-1:0]    len;
        logic [CMD_SEL_W-1:0]    chain;
        logic [CMD_MAX_BITS-1:0] tms;
        logic [CMD_MAX_BITS-1:0] tdi;
    } jtag_cmd_t;

endpackage

// File: rtl/jtag_shift_engine_tck_gen.sv
// TCK phase generator: while en is high, emits rise_stb after CLK_DIV
// cycles, then fall_stb after CLK_DIV more, alternating.
// Ports: clk, rst, en in; rise_stb, fall_stb one-cycle strobes out.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          wrap;

    assign wrap = (cnt == CW'(CLK_DIV - 1));

    // Held cleared while disabled, so every enable starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign rise_stb = en & wrap & ~phase;
    assign fall_stb = en & wrap & phase;

endmodule

// File: rtl/jtag_shift_engine.sv
// JTAG master: shifts packed TMS/TDI commands onto one of NUM_CHAINS
// TAP chains with a divided TCK and returns captured TDO.
// Ports: cmd_* command in (valid/ready), rsp_* response out
// (valid/ready), busy, and per-chain tck/tms/tdi out, tdo in.
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter int MAX_BITS   = 64,
    parameter int CLK_DIV    = 2,
    parameter int NUM_CHAINS = 1,
    parameter int LEN_W      = len_w(MAX_BITS),
    parameter int SEL_W      = sel_w(NUM_CHAINS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [SEL_W-1:0]      cmd_chain,
    input  logic [MAX_BITS-1:0]   cmd_tms,
    input  logic [MAX_BITS-1:0]   cmd_tdi,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MAX_BITS-1:0]   rsp_tdo,
    output logic [LEN_W-1:0]      rsp_len,
    output logic                  busy,
    output logic [NUM_CHAINS-1:0] tck,
    output logic [NUM_CHAINS-1:0] tms,
    output logic [NUM_CHAINS-1:0] tdi,
    input  logic [NUM_CHAINS-1:0] tdo
);

    state_t               state;
    state_t               state_nx;
    logic [SEL_W-1:0]     sel;
    logic [LEN_W-1:0]     rem;
    logic [MAX_BITS-1:0]  tms_sh;
    logic [MAX_BITS-1:0]  tdi_sh;
    logic [MAX_BITS-1:0]  mask;
    logic                 accept;
    logic                 chain_ok;
    logic [LEN_W-1:0]     eff_len;
    logic                 tdo_sel;
    logic                 rise_stb;
    logic                 fall_stb;
    logic                 last_bit;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_valid & cmd_ready;
    assign last_bit  = (rem == LEN_W'(1));

    // Out-of-range chains are accepted but shift nothing.
    assign chain_ok = int'(cmd_chain) < NUM_CHAINS;
    assign eff_len  = !chain_ok ? '0 :
                      (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) :
                      cmd_len;

    always_comb begin
        tdo_sel = 1'b0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            if (SEL_W'(c) == sel) tdo_sel = tdo[c];
        end
    end

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       ((state == LOW) || (state == HIGH)),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (eff_len == '0) ? RESP : LOW;
            LOW:  if (rise_stb) state_nx = HIGH;
            HIGH: if (fall_stb) state_nx = last_bit ? RESP : LOW;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel     <= '0;
            rem     <= '0;
            tms_sh  <= '0;
            tdi_sh  <= '0;
            mask    <= '0;
            rsp_tdo <= '0;
            rsp_len <= '0;
            tck     <= '0;
            tms     <= '0;
            tdi     <= '0;
        end else begin
            // Registered from next state so TCK is glitch-free.
            tck <= '0;
            for (int c = 0; c < NUM_CHAINS; c++) begin
                if (state_nx == HIGH && SEL_W'(c) == sel) tck[c] <= 1'b1;
            end

            if (accept) begin
                sel     <= cmd_chain;
                rem     <= eff_len;
                rsp_len <= eff_len;
                rsp_tdo <= '0;
                mask    <= MAX_BITS'(1);
                tms_sh  <= cmd_tms >> 1;
                tdi_sh  <= cmd_tdi >> 1;
                for (int c = 0; c < NUM_CHAINS; c++) begin
                    if (eff_len != '0 && SEL_W'(c) == cmd_chain) begin
                        tms[c] <= cmd_tms[0];
                        tdi[c] <= cmd_tdi[0];
                    end
                end
            end

            // TDO captured on the same edge that raises TCK.
            if (rise_stb && tdo_sel) rsp_tdo <= rsp_tdo | mask;

            if (fall_stb) begin
                rem    <= rem - 1'b1;
                mask   <= mask << 1;
                tms_sh <= tms_sh >> 1;
                tdi_sh <= tdi_sh >> 1;
                for (int c = 0; c < NUM_CHAINS; c++) begin
                    if (!last_bit && SEL_W'(c) == sel) begin
                        tms[c] <= tms_sh[0];
                        tdi[c] <= tdi_sh[0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Self-checking bench for jtag_shift_engine with 5 chains, CLK_DIV=2,
// 64-bit commands, driven by directed and random shift commands.
module tb_jtag_shift_engine;

    localparam int MB = 64;
    localparam int D  = 2;
    localparam int NC = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [6:0]    cmd_len;
    logic [2:0]    cmd_chain;
    logic [63:0]   cmd_tms;
    logic [63:0]   cmd_tdi;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_tdo;
    logic [6:0]    rsp_len;
    logic          busy;
    logic [NC-1:0] tck;
    logic [NC-1:0] tms;
    logic [NC-1:0] tdi;
    logic [NC-1:0] tdo;

    int n_tests = 0;
    int n_fail  = 0;

    jtag_shift_engine #(
        .MAX_BITS   (MB),
        .CLK_DIV    (D),
        .NUM_CHAINS (NC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_chain (cmd_chain),
        .cmd_tms   (cmd_tms),
        .cmd_tdi   (cmd_tdi),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tdo   (rsp_tdo),
        .rsp_len   (rsp_len),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    // Target TAP model: each chain returns pat bit k before rise k.
    logic [63:0] pat [NC];
    int          falls [NC];
    int          pulses [NC];
    int          run [NC];
    int          hmin [NC];
    int          hmax [NC];
    int          lmin [NC];
    int          lmax [NC];
    logic [63:0] rec_tms [NC];
    logic [63:0] rec_tdi [NC];
    logic [NC-1:0] ptck;
    logic        mon_clr = 1'b0;

    always_comb begin
        for (int c = 0; c < NC; c++) tdo[c] = pat[c][falls[c] % 64];
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int c = 0; c < NC; c++) begin
                falls[c] = 0; pulses[c] = 0; run[c] = 0;
                hmin[c] = 1000; hmax[c] = 0;
                lmin[c] = 1000; lmax[c] = 0;
                rec_tms[c] = '0; rec_tdi[c] = '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (tck[c] != ptck[c]) begin
                    if (tck[c]) begin
                        if (pulses[c] > 0) begin
                            if (run[c] < lmin[c]) lmin[c] = run[c];
                            if (run[c] > lmax[c]) lmax[c] = run[c];
                        end
                        if (pulses[c] < 64) begin
                            rec_tms[c][pulses[c]] = tms[c];
                            rec_tdi[c][pulses[c]] = tdi[c];
                        end
                        pulses[c]++;
                    end else begin
                        if (run[c] < hmin[c]) hmin[c] = run[c];
                        if (run[c] > hmax[c]) hmax[c] = run[c];
                        falls[c]++;
                    end
                    run[c] = 1;
                end else begin
                    run[c]++;
                end
            end
        end
        ptck = tck;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int len, input int chain);
        if (chain >= NC) return 0;
        return (len > MB) ? MB : len;
    endfunction

    function automatic logic [63:0] lowmask(input int n);
        logic [63:0] one = 64'd1;
        if (n >= 64) return '1;
        return (one << n) - 64'd1;
    endfunction

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(posedge clk);
        mon_clr = 1'b0;
        @(negedge clk);
    endtask

    // Offer a command at a negedge; it is taken on the next posedge.
    task automatic send(input int len, input int chain,
                        input logic [63:0] tv, input logic [63:0] dv);
        cmd_len   = 7'(len);
        cmd_chain = 3'(chain);
        cmd_tms   = tv;
        cmd_tdi   = dv;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_len   = 7'($urandom);
        cmd_chain = 3'($urandom);
        cmd_tms   = {$urandom, $urandom};
        cmd_tdi   = {$urandom, $urandom};
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 400);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input int len,
                             input int chain, input logic [63:0] tv,
                             input logic [63:0] dv);
        int e;
        int lat;
        e = eff(len, chain);
        clear_mon();
        send(len, chain, tv, dv);
        wait_rsp(lat);
        chk({tag, "_lat"}, 64'(lat), (e == 0) ? 64'd1 : 64'(2 * D * e + 1));
        chk({tag, "_len"}, 64'(rsp_len), 64'(e));
        chk({tag, "_tdo"}, rsp_tdo,
            (e == 0) ? 64'd0 : (pat[chain % 8 % NC] & lowmask(e)));
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s_pulses%0d", tag, c), 64'(pulses[c]),
                (c == chain) ? 64'(e) : 64'd0);
        end
        if (e > 0) begin
            chk({tag, "_tms"}, rec_tms[chain], tv & lowmask(e));
            chk({tag, "_tdi"}, rec_tdi[chain], dv & lowmask(e));
            chk({tag, "_hmin"}, 64'(hmin[chain]), 64'(D));
            chk({tag, "_hmax"}, 64'(hmax[chain]), 64'(D));
        end
        if (e > 1) begin
            chk({tag, "_lmin"}, 64'(lmin[chain]), 64'(D));
            chk({tag, "_lmax"}, 64'(lmax[chain]), 64'(D));
        end
        handshake();
        chk({tag, "_idle"}, 64'({cmd_ready, busy}), 64'b10);
    endtask

    initial begin
        int lat;
        int k;
        logic ok;
        logic [63:0] snap;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_chain = '0;
        cmd_tms   = '0;
        cmd_tdi   = '0;
        rsp_ready = 1'b0;
        for (int c = 0; c < NC; c++) pat[c] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tck", 64'(tck), 64'd0);
        chk("rst_tms", 64'(tms), 64'd0);
        chk("rst_tdi", 64'(tdi), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_rsp", {rsp_tdo[56:0], rsp_len}, 64'd0);

        pat[0] = 64'b01101;
        run_check("basic", 5, 0, 64'b00110, 64'b10101);
        run_check("len0", 0, 1, 64'hffff, 64'hffff);
        run_check("over", MB + 3, 3, {$urandom, $urandom},
                  {$urandom, $urandom});
        run_check("chain2", 8, 2, 64'ha5, 64'h3c);
        run_check("chain5", 8, 5, 64'ha5, 64'h3c);

        // Response back-pressure with a competing command offered.
        clear_mon();
        send(3, 1, 64'h5, 64'h2);
        wait_rsp(lat);
        snap = rsp_tdo;
        chk("bp_tdo", snap, pat[1] & 64'h7);
        cmd_len   = 7'd2;
        cmd_chain = 3'd0;
        cmd_tms   = 64'h3;
        cmd_tdi   = 64'h1;
        cmd_valid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_tdo !== snap || rsp_len !== 7'd3 ||
                rsp_valid !== 1'b1 || cmd_ready !== 1'b0) ok = 1'b0;
        end
        chk("bp_stable", 64'(ok), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_not_yet", 64'({cmd_ready, busy}), 64'b10);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("bp_next_lat", 64'(lat), 64'(2 * D * 2 + 1));
        chk("bp_next_len", 64'(rsp_len), 64'd2);
        handshake();

        // Reset in the middle of a len=8 shift.
        clear_mon();
        send(8, 1, 64'hff, 64'hff);
        k = 0;
        while (pulses[1] < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reach", 64'(pulses[1]), 64'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_tck", 64'(tck), 64'd0);
        chk("mid_pins", 64'({tms, tdi}), 64'd0);
        chk("mid_state", 64'({busy, rsp_valid, cmd_ready}), 64'b001);
        chk("mid_rsp", {rsp_tdo[56:0], rsp_len}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("mid_no_rsp", 64'(ok), 64'd1);
        run_check("after_rst", 6, 1, 64'h2d, 64'h1b);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < NC; c++) pat[c] = {$urandom, $urandom};
            run_check($sformatf("rnd%0d", r), $urandom_range(0, 70),
                      $urandom_range(0, 7), {$urandom, $urandom},
                      {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
